// File: rtl/booth_seq_ctrl_if.sv
// Request/response bundle for the sequential Booth multiplier.
// The master issues operands with a start strobe; the slave reports busy,
// a one-cycle done pulse and the held product.
interface booth_seq_ctrl_if #(
    parameter int unsigned WIDTH = 4
);
    logic                 start;
    logic [WIDTH-1:0]     a;
    logic [WIDTH-1:0]     b;
    logic                 busy;
    logic                 done;
    logic [2*WIDTH-1:0]   prod;

    modport master (
        output start,
        output a,
        output b,
        input  busy,
        input  done,
        input  prod
    );

    modport slave (
        input  start,
        input  a,
        input  b,
        output busy,
        output done,
        output prod
    );
endinterface

// File: rtl/booth_seq_ctrl.sv
// Iterative radix-2 Booth multiplier controller.
// One add/sub-and-shift step per clock over WIDTH cycles. The operands are
// latched when START is accepted in IDLE. BUSY marks the CALC phase. DONE
// pulses for one cycle when PROD is updated, and PROD holds that value until
// the next completion or reset.
module booth_seq_ctrl #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    booth_seq_ctrl_if.slave  bus
);

    // Accumulator is one bit wider so that negating M = -2^(WIDTH-1) cannot overflow.
    localparam int unsigned AW = WIDTH + 1;
    localparam int unsigned PW = 2 * WIDTH;
    localparam int unsigned CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_CALC = 1'b1
    } state_e;

    state_e          state_q, state_d;
    logic [AW-1:0]   m_q,     m_d;
    logic [AW-1:0]   acc_q,   acc_d;
    logic [WIDTH-1:0] q_q,    q_d;
    logic            e1_q,    e1_d;
    logic [CW-1:0]   cnt_q,   cnt_d;
    logic            busy_q,  busy_d;
    logic            done_q,  done_d;
    logic [PW-1:0]   prod_q,  prod_d;

    // Combinational results of the current Booth step
    logic [AW-1:0]    acc_t_c;
    logic [AW-1:0]    acc_sh_c;
    logic [WIDTH-1:0] q_sh_c;

    // Booth step: add/sub M according to {Q[0],E1}, then arithmetic shift right
    always_comb begin
        acc_t_c = acc_q;
        unique case ({q_q[0], e1_q})
            2'b10:   acc_t_c = acc_q - m_q;
            2'b01:   acc_t_c = acc_q + m_q;
            default: acc_t_c = acc_q;
        endcase
        acc_sh_c = {acc_t_c[AW-1], acc_t_c[AW-1:1]};
        q_sh_c   = {acc_t_c[0], q_q[WIDTH-1:1]};
    end

    // Next-state and register-update logic
    always_comb begin
        state_d = state_q;
        m_d     = m_q;
        acc_d   = acc_q;
        q_d     = q_q;
        e1_d    = e1_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        prod_d  = prod_q;

        unique case (state_q)
            ST_IDLE: begin
                busy_d = 1'b0;
                if (bus.start) begin
                    m_d     = {bus.b[WIDTH-1], bus.b};
                    q_d     = bus.a;
                    acc_d   = '0;
                    e1_d    = 1'b0;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    state_d = ST_CALC;
                end
            end
            ST_CALC: begin
                acc_d = acc_sh_c;
                q_d   = q_sh_c;
                e1_d  = q_q[0];
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == LAST_CNT) begin
                    prod_d  = {acc_sh_c[WIDTH-1:0], q_sh_c};
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            m_q     <= '0;
            acc_q   <= '0;
            q_q     <= '0;
            e1_q    <= 1'b0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            prod_q  <= '0;
        end else begin
            state_q <= state_d;
            m_q     <= m_d;
            acc_q   <= acc_d;
            q_q     <= q_d;
            e1_q    <= e1_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            prod_q  <= prod_d;
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.prod = prod_q;

endmodule

// File: tb/tb_booth_seq_ctrl.sv
// Scoreboard bench for booth_seq_ctrl: a WIDTH=4 instance for the directed and
// exhaustive cases and a WIDTH=8 instance for the wide-operand smoke test.
module tb_booth_seq_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;

    int n_checks = 0;
    int n_pass   = 0;
    int done_cnt4 = 0;
    int done_cnt8 = 0;

    logic [7:0]  exp_q4[$];
    logic [15:0] exp_q8[$];

    booth_seq_ctrl_if #(.WIDTH(4)) bus4();
    booth_seq_ctrl_if #(.WIDTH(8)) bus8();

    booth_seq_ctrl #(.WIDTH(4)) dut4 (.clk_i(clk), .rst_i(rst), .bus(bus4));
    booth_seq_ctrl #(.WIDTH(8)) dut8 (.clk_i(clk), .rst_i(rst), .bus(bus8));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endfunction

    // Monitor for the WIDTH=4 instance
    initial begin
        int run = 0;
        bit pb = 1'b0;
        bit pd = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                run = 0; pb = 1'b0; pd = 1'b0;
            end else begin
                if (bus4.busy) begin
                    if (!pb) run = 0;
                    run++;
                end
                if (bus4.done) begin
                    done_cnt4++;
                    check("done4_no_repeat", 64'(pd), 64'd0);
                    check("done4_busy_cycles", pb ? 64'(run) : 64'hFFFF, 64'd4);
                    if (exp_q4.size() == 0) check("done4_unexpected", 64'd1, 64'd0);
                    else check("prod4", 64'(bus4.prod), 64'(exp_q4.pop_front()));
                end
                pb = bus4.busy;
                pd = bus4.done;
            end
        end
    end

    // Monitor for the WIDTH=8 instance
    initial begin
        int run = 0;
        bit pb = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                run = 0; pb = 1'b0;
            end else begin
                if (bus8.busy) begin
                    if (!pb) run = 0;
                    run++;
                end
                if (bus8.done) begin
                    done_cnt8++;
                    check("done8_busy_cycles", pb ? 64'(run) : 64'hFFFF, 64'd8);
                    if (exp_q8.size() == 0) check("done8_unexpected", 64'd1, 64'd0);
                    else check("prod8", 64'(bus8.prod), 64'(exp_q8.pop_front()));
                end
                pb = bus8.busy;
            end
        end
    end

    task automatic wait_idle4();
        int n = 0;
        @(negedge clk);
        while (bus4.busy && n < 50) begin @(negedge clk); n++; end
        if (bus4.busy) check("idle4_timeout", 64'd1, 64'd0);
    endtask

    task automatic issue4(input logic [3:0] a, input logic [3:0] b, input logic [7:0] exp, input bit push);
        wait_idle4();
        bus4.start = 1'b1; bus4.a = a; bus4.b = b;
        @(posedge clk);
        if (push) exp_q4.push_back(exp);
        #1 bus4.start = 1'b0;
    endtask

    task automatic issue8(input logic [7:0] a, input logic [7:0] b, input logic [15:0] exp);
        int n = 0;
        @(negedge clk);
        while (bus8.busy && n < 50) begin @(negedge clk); n++; end
        if (bus8.busy) check("idle8_timeout", 64'd1, 64'd0);
        bus8.start = 1'b1; bus8.a = a; bus8.b = b;
        @(posedge clk);
        exp_q8.push_back(exp);
        #1 bus8.start = 1'b0;
    endtask

    task automatic wait_drain(input int limit);
        int n = 0;
        while ((exp_q4.size() != 0 || exp_q8.size() != 0) && n < limit) begin
            @(negedge clk); n++;
        end
        check("queues_drained", 64'(exp_q4.size() + exp_q8.size()), 64'd0);
    endtask

    task automatic wait_done4(output int at);
        int n = 0;
        do begin @(negedge clk); n++; end while (!bus4.done && n < 50);
        if (!bus4.done) check("done4_timeout", 64'd1, 64'd0);
        at = cyc;
    endtask

    initial begin
        int t_prev, t_now, dc;
        bus4.start = 1'b0; bus4.a = '0; bus4.b = '0;
        bus8.start = 1'b0; bus8.a = '0; bus8.b = '0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_busy4", 64'(bus4.busy), 64'd0);
        check("rst_done4", 64'(bus4.done), 64'd0);
        check("rst_prod4", 64'(bus4.prod), 64'd0);
        check("rst_prod8", 64'(bus8.prod), 64'd0);
        rst = 1'b0;

        // 3 * -2 = -6, product held afterwards
        issue4(4'd3, 4'hE, 8'hFA, 1'b1);
        wait_drain(20);
        repeat (3) @(negedge clk);
        check("prod4_hold", 64'(bus4.prod), 64'hFA);

        // Corner operands, plus a START pulse while busy that must be ignored
        issue4(4'h8, 4'h8, 8'h40, 1'b1);
        issue4(4'h8, 4'h7, 8'hC8, 1'b1);
        issue4(4'h7, 4'h7, 8'h31, 1'b1);
        @(negedge clk);
        bus4.start = 1'b1; bus4.a = 4'd1; bus4.b = 4'd1;
        @(negedge clk);
        bus4.start = 1'b0;
        wait_drain(20);

        // START held high; operands change mid-flight and only affect later issues
        wait_idle4();
        bus4.start = 1'b1; bus4.a = 4'd2; bus4.b = 4'd5;
        @(posedge clk);
        exp_q4.push_back(8'd10);
        repeat (2) @(negedge clk);
        bus4.a = 4'hD; bus4.b = 4'd4;
        exp_q4.push_back(8'hF4);
        exp_q4.push_back(8'hF4);
        wait_done4(t_prev);
        for (int k = 0; k < 2; k++) begin
            wait_done4(t_now);
            check("issue_interval", 64'(t_now - t_prev), 64'd5);
            t_prev = t_now;
        end
        bus4.start = 1'b0;
        wait_drain(20);

        // Reset two cycles into CALC abandons the operation
        issue4(4'd5, 4'd3, 8'd0, 1'b0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("abort_busy", 64'(bus4.busy), 64'd0);
        check("abort_done", 64'(bus4.done), 64'd0);
        check("abort_prod", 64'(bus4.prod), 64'd0);
        rst = 1'b0;
        dc = done_cnt4;
        repeat (8) @(negedge clk);
        check("abort_no_done", 64'(done_cnt4), 64'(dc));
        issue4(4'hF, 4'hF, 8'd1, 1'b1);
        wait_drain(20);

        // Exhaustive back-to-back issue
        dc = done_cnt4;
        for (int ai = -8; ai < 8; ai++) begin
            for (int bi = -8; bi < 8; bi++) begin
                issue4(4'(ai), 4'(bi), 8'(ai * bi), 1'b1);
            end
        end
        wait_drain(20);
        check("exhaustive_done_count", 64'(done_cnt4 - dc), 64'd256);

        // WIDTH=8 smoke test
        issue8(8'h80, 8'h80, 16'h4000);
        issue8(8'h7F, 8'h80, 16'hC080);
        wait_drain(30);
        check("done8_count", 64'(done_cnt8), 64'd2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1);
    end

endmodule
